// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: fixed-priority, starvation-guarded two-port arbiter for a single-port data memory
module data_memory_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req0,
    input  logic        We0,
    input  logic [31:0] Addr0,
    input  logic [31:0] Wdata0,
    output logic        Ack0,
    output logic        Err0,
    output logic [31:0] Rdata0,
    input  logic        Req1,
    input  logic        We1,
    input  logic [31:0] Addr1,
    input  logic [31:0] Wdata1,
    output logic        Ack1,
    output logic        Err1,
    output logic [31:0] Rdata1,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] MemReadData,
    output logic        Busy,
    output logic        Grant
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    state_t state_q, state_d;
    logic grant_q, grant_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [3:0] cnt_q, cnt_d;
    logic mis, pick1;
    logic [31:0] rd_val;
    always_comb begin
        mis = addr_q[1:0] != 2'b00;
        pick1 = Req1 && (!Req0 || cnt_q == LIMIT);
        rd_val = mis ? 32'd0 : MemReadData;
        state_d = state_q;
        grant_d = grant_q;
        we_d = we_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            // a port-0 win over a waiting port 1 is the only case that grows the counter
            cnt_d = (Req1 && !pick1) ? cnt_q + 4'd1 : 4'd0;
            if (Req0 || Req1) begin
                state_d = ISSUE;
                grant_d = pick1;
                we_d = pick1 ? We1 : We0;
                addr_d = pick1 ? Addr1 : Addr0;
                wdata_d = pick1 ? Wdata1 : Wdata0;
            end
        end else if (state_q == ISSUE) begin
            state_d = RESP;
            if (mis || !we_q) begin
                rdata0_d = grant_q ? rdata0_q : rd_val;
                rdata1_d = grant_q ? rd_val : rdata1_q;
            end
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            we_q <= 1'b0;
            addr_q <= 32'd0;
            wdata_q <= 32'd0;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
            cnt_q <= 4'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            we_q <= we_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            cnt_q <= cnt_d;
        end
    end
    assign MemAddress = addr_q;
    assign MemWriteData = wdata_q;
    assign MemWrite = state_q == ISSUE && we_q && !mis && !Reset;
    assign MemRead = state_q == ISSUE && !we_q && !mis;
    assign Ack0 = state_q == RESP && !grant_q;
    assign Ack1 = state_q == RESP && grant_q;
    assign Err0 = Ack0 && mis;
    assign Err1 = Ack1 && mis;
    assign Rdata0 = rdata0_q;
    assign Rdata1 = rdata1_q;
    assign Busy = state_q != IDLE;
    assign Grant = grant_q;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed vector bench with a behavioural data memory
module tb_data_memory_arbiter;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic Req0 = 1'b0, We0 = 1'b0, Req1 = 1'b0, We1 = 1'b0;
    logic [31:0] Addr0 = 32'd0, Wdata0 = 32'd0, Addr1 = 32'd0, Wdata1 = 32'd0;
    logic Ack0, Err0, Ack1, Err1, MemWrite, MemRead, Busy, Grant;
    logic [31:0] Rdata0, Rdata1, MemAddress, MemWriteData, MemReadData;
    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    data_memory_arbiter #(.STARVE_LIMIT(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .We0(We0), .Addr0(Addr0), .Wdata0(Wdata0),
        .Ack0(Ack0), .Err0(Err0), .Rdata0(Rdata0),
        .Req1(Req1), .We1(We1), .Addr1(Addr1), .Wdata1(Wdata1),
        .Ack1(Ack1), .Err1(Err1), .Rdata1(Rdata1),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData),
        .Busy(Busy), .Grant(Grant)
    );

    // memory: words 0..2 preloaded, everything else reads 0 until written
    logic [31:0] mem [0:63];
    logic [63:0] wv = '0;
    function automatic logic [31:0] pre(input logic [5:0] i);
        return i == 6'd0 ? 32'h11111111 : i == 6'd1 ? 32'h22222222 : i == 6'd2 ? 32'h33333333 : 32'd0;
    endfunction
    always @(posedge Clk) begin
        if (MemWrite) begin
            mem[MemAddress[7:2]] <= MemWriteData;
            wv[MemAddress[7:2]] <= 1'b1;
        end
    end
    assign MemReadData = wv[MemAddress[7:2]] ? mem[MemAddress[7:2]] : pre(MemAddress[7:2]);

    always @(negedge Clk) begin
        if (Ack0 && Ack1) begin
            errors++;
            $display("FAIL ack_overlap: Ack0=%b Ack1=%b required not both high at %0t", Ack0, Ack1, $time);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit p, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        if (p) begin
            Req1 = r; We1 = w; Addr1 = a; Wdata1 = d;
        end else begin
            Req0 = r; We0 = w; Addr0 = a; Wdata0 = d;
        end
    endtask

    typedef struct {
        bit port;
        bit we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        bit err;
    } vec_t;

    task automatic txn(input vec_t v);
        int n = 0, wr = 0, rd = 0;
        bit got = 0;
        logic [31:0] wd = 32'd0;
        @(negedge Clk);
        drive(v.port, 1, v.we, v.addr, v.wdata);
        while (!got && n < 10) begin
            @(posedge Clk);
            n++;
            @(negedge Clk);
            wr += int'(MemWrite);
            rd += int'(MemRead);
            if (MemWrite) wd = MemWriteData;
            if (MemWrite || MemRead) chk("mem_address", MemAddress, v.addr);
            got = v.port ? Ack1 : Ack0;
        end
        chk("ack_latency", got ? 32'(n) : 32'd99, 32'd2);
        chk("ack_grant", 32'(Grant), 32'(v.port));
        chk("err", 32'(v.port ? Err1 : Err0), 32'(v.err));
        if (!v.we || v.err) chk("rdata", v.port ? Rdata1 : Rdata0, v.rd);
        chk("mem_write_cycles", 32'(wr), 32'(v.we && !v.err));
        chk("mem_read_cycles", 32'(rd), 32'(!v.we && !v.err));
        if (v.we && !v.err) chk("mem_write_data", wd, v.wdata);
        drive(v.port, 0, 0, 32'd0, 32'd0);
    endtask

    vec_t vecs [8];
    bit exp_g [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic [31:0] b2b_exp [3] = '{32'h11111111, 32'h22222222, 32'h33333333};

    initial begin
        vecs[0] = '{0, 1, 32'h10, 32'hDEADBEEF, 32'h0, 0};
        vecs[1] = '{0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0};
        vecs[2] = '{1, 1, 32'h14, 32'hCAFEF00D, 32'h0, 0};
        vecs[3] = '{1, 0, 32'h14, 32'h0, 32'hCAFEF00D, 0};
        vecs[4] = '{1, 0, 32'h6, 32'h0, 32'h0, 1};
        vecs[5] = '{0, 1, 32'h13, 32'hBAD, 32'h0, 1};
        vecs[6] = '{0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0};
        vecs[7] = '{1, 0, 32'h0, 32'h0, 32'h11111111, 0};

        Req0 = 1'($urandom); We0 = 1'($urandom); Addr0 = $urandom; Wdata0 = $urandom;
        Req1 = 1'($urandom); We1 = 1'($urandom); Addr1 = $urandom; Wdata1 = $urandom;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("reset_data_outs", MemAddress | MemWriteData | Rdata0 | Rdata1, 32'd0);
        chk("reset_strobes", 32'({Ack0, Err0, Ack1, Err1, MemWrite, MemRead, Busy, Grant}), 32'd0);
        Reset = 1'b0;
        drive(0, 0, 0, 32'd0, 32'd0);
        drive(1, 0, 0, 32'd0, 32'd0);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("idle_data_outs", MemAddress | MemWriteData | Rdata0 | Rdata1, 32'd0);
        chk("idle_strobes", 32'({Ack0, Err0, Ack1, Err1, MemWrite, MemRead, Busy, Grant}), 32'd0);

        for (int i = 0; i < 8; i++) txn(vecs[i]);

        begin
            int k = 0, cyc = 0;
            @(negedge Clk);
            drive(0, 1, 0, 32'h0, 32'd0);
            drive(1, 1, 0, 32'h4, 32'd0);
            while (k < 10 && cyc < 100) begin
                @(posedge Clk);
                cyc++;
                @(negedge Clk);
                if (Ack0 || Ack1) begin
                    chk($sformatf("grant_seq%0d", k), 32'(Ack1), 32'(exp_g[k]));
                    chk("starve_rdata", Ack1 ? Rdata1 : Rdata0, Ack1 ? 32'h22222222 : 32'h11111111);
                    k++;
                end
            end
            chk("starve_done", 32'(k), 32'd10);
            drive(0, 0, 0, 32'd0, 32'd0);
            drive(1, 0, 0, 32'd0, 32'd0);
        end

        @(negedge Clk);
        @(negedge Clk);
        drive(0, 1, 1, 32'h20, 32'h55);
        @(posedge Clk);
        @(negedge Clk);
        chk("issue_write_pending", 32'(MemWrite), 32'd1);
        Reset = 1'b1;
        #1;
        chk("mem_write_gated", 32'(MemWrite), 32'd0);
        drive(0, 0, 0, 32'd0, 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        chk("busy_after_reset", 32'({Busy, Ack0}), 32'd0);
        Reset = 1'b0;
        txn('{0, 0, 32'h20, 32'h0, 32'h0, 0});

        begin
            int k = 0, cyc = 0, last = 0;
            @(negedge Clk);
            drive(1, 1, 0, 32'h0, 32'd0);
            while (k < 3 && cyc < 40) begin
                @(posedge Clk);
                cyc++;
                @(negedge Clk);
                if (Ack1) begin
                    chk($sformatf("b2b_rdata%0d", k), Rdata1, b2b_exp[k]);
                    chk($sformatf("b2b_gap%0d", k), 32'(cyc - last), k == 0 ? 32'd2 : 32'd3);
                    chk("b2b_starve_cnt", 32'(dut.cnt_q), 32'd0);
                    last = cyc;
                    k++;
                    Addr1 = 32'(k * 4);
                end
            end
            chk("b2b_done", 32'(k), 32'd3);
            drive(1, 0, 0, 32'd0, 32'd0);
        end

        repeat (2) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
